// File: rtl/loop_buffer_pkg.sv
// rtl/loop_buffer_pkg.sv - FSM state type and block-length helper shared by the loop buffer reader
package loop_buffer_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, RELEASE} rd_state_e;

  // A programmed length of zero selects a full block of 2**aw words.
  function automatic int unsigned blk_len_words(input int unsigned cfg, input int unsigned aw);
    return (cfg == 0) ? (32'd1 << aw) : cfg;
  endfunction

endpackage

// File: rtl/loop_buffer_block_reader_if.sv
// rtl/loop_buffer_block_reader_if.sv - block-info/RAM-read/output-stream bundle of the loop buffer reader
interface loop_buffer_block_reader_if #(
  parameter int RDATA_WIDTH = 64,
  parameter int RADDR_WIDTH = 8,
  parameter int INFO_WIDTH  = 256
);
  logic                   buf_info_vld;
  logic [INFO_WIDTH-1:0]  buf_info;
  logic [RADDR_WIDTH-1:0] buf_addr;
  logic [RDATA_WIDTH-1:0] buf_data;
  logic                   buf_rdy;
  logic                   m_valid;
  logic                   m_ready;
  logic [RDATA_WIDTH-1:0] m_data;
  logic                   m_sof;
  logic                   m_eof;
  logic [INFO_WIDTH-1:0]  m_info;

  modport master (
    input  buf_info_vld, buf_info, buf_data, m_ready,
    output buf_addr, buf_rdy, m_valid, m_data, m_sof, m_eof, m_info
  );

  modport slave (
    output buf_info_vld, buf_info, buf_data, m_ready,
    input  buf_addr, buf_rdy, m_valid, m_data, m_sof, m_eof, m_info
  );
endinterface

// File: rtl/loop_buffer_skid_fifo.sv
// rtl/loop_buffer_skid_fifo.sv - small sync FIFO absorbing RAM read latency, exposes occupancy for credit
module loop_buffer_skid_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_rd;

  assign do_rd = rd_en && (count_q != '0);
  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && !do_rd) begin
        assert (count_q != CNT_W'(DEPTH)) else $error("skid fifo overflow");
        count_q <= count_q + CNT_W'(1);
      end else if (!wr_en && do_rd) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/loop_buffer_block_reader.sv
// rtl/loop_buffer_block_reader.sv - read engine: sweeps a committed block, streams it out, releases it
// Optional LOOP_RD_STATS_EN adds released-block and stall-cycle counters.
module loop_buffer_block_reader
  import loop_buffer_pkg::*;
#(
  parameter int RDATA_WIDTH  = 64,
  parameter int RADDR_WIDTH  = 8,
  parameter int READ_LATENCY = 3,
  parameter int INFO_WIDTH   = 256,
  parameter int OFIFO_DEPTH  = 8
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst_n,
  input  logic [RADDR_WIDTH:0]   cfg_blk_len,
  loop_buffer_block_reader_if.master bus,
  output logic                   busy,
  output logic [31:0]            blk_cnt,
  output logic [31:0]            stall_cnt
);
  localparam int LW = RADDR_WIDTH + 1;
  localparam int CW = $clog2(OFIFO_DEPTH) + 1;
  localparam int FW = RDATA_WIDTH + 2;

  rd_state_e              state_q;
  logic [LW-1:0]          len_q, issue_cnt_q;
  logic [RADDR_WIDTH-1:0] addr_q;
  logic                   buf_rdy_q;
  logic [INFO_WIDTH-1:0]  info_q;
  logic [READ_LATENCY-1:0] vld_pipe_q, sof_pipe_q, eof_pipe_q;
  logic [CW-1:0]          inflight, fifo_cnt;
  logic [CW:0]            occupancy;
  logic                   credit, issue, last_issue;
  logic [FW-1:0]          fifo_rdata;
  logic                   fifo_empty, m_valid, fifo_pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(vld_pipe_q[i]);
  end

  // Reads in flight already own a FIFO slot, so the FIFO can never overflow.
  assign occupancy  = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign credit     = occupancy < (CW+1)'(OFIFO_DEPTH);
  assign issue      = (state_q == READ) && credit;
  assign last_issue = issue && (issue_cnt_q == len_q - LW'(1));

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issue_cnt_q <= '0;
      addr_q      <= '0;
      buf_rdy_q   <= 1'b0;
      info_q      <= '0;
    end else begin
      buf_rdy_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.buf_info_vld) begin
          info_q      <= bus.buf_info;
          len_q       <= LW'(blk_len_words(32'(cfg_blk_len), RADDR_WIDTH));
          issue_cnt_q <= '0;
          addr_q      <= '0;
          state_q     <= READ;
        end
        READ: if (issue) begin
          issue_cnt_q <= issue_cnt_q + LW'(1);
          // The address stays on the last word so a full block never wraps to 0.
          if (last_issue) state_q <= DRAIN;
          else            addr_q  <= addr_q + RADDR_WIDTH'(1);
        end
        DRAIN: if (inflight == '0 && fifo_cnt == '0) begin
          state_q   <= RELEASE;
          buf_rdy_q <= 1'b1;
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      vld_pipe_q <= '0;
      sof_pipe_q <= '0;
      eof_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= issue;
      sof_pipe_q[0] <= issue && (issue_cnt_q == '0);
      eof_pipe_q[0] <= last_issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        sof_pipe_q[i] <= sof_pipe_q[i-1];
        eof_pipe_q[i] <= eof_pipe_q[i-1];
      end
    end
  end

  loop_buffer_skid_fifo #(.WIDTH(FW), .DEPTH(OFIFO_DEPTH), .CNT_W(CW)) u_fifo (
    .clk   (rd_clk),
    .rst_n (rd_rst_n),
    .wr_en (vld_pipe_q[READ_LATENCY-1]),
    .wdata ({sof_pipe_q[READ_LATENCY-1], eof_pipe_q[READ_LATENCY-1], bus.buf_data}),
    .rd_en (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign m_valid      = !fifo_empty;
  assign fifo_pop     = m_valid && bus.m_ready;
  assign bus.m_valid  = m_valid;
  assign bus.m_data   = m_valid ? fifo_rdata[RDATA_WIDTH-1:0] : '0;
  assign bus.m_sof    = m_valid && fifo_rdata[RDATA_WIDTH+1];
  assign bus.m_eof    = m_valid && fifo_rdata[RDATA_WIDTH];
  assign bus.m_info   = info_q;
  assign bus.buf_addr = addr_q;
  assign bus.buf_rdy  = buf_rdy_q;
  assign busy         = (state_q != IDLE);

`ifdef LOOP_RD_STATS_EN
  logic [31:0] blk_cnt_q, stall_cnt_q;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      blk_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (buf_rdy_q) blk_cnt_q <= blk_cnt_q + 32'd1;
      if (m_valid && !bus.m_ready && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign blk_cnt   = blk_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign blk_cnt   = '0;
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_loop_buffer_block_reader.sv
// tb/tb_loop_buffer_block_reader.sv - scoreboard bench for the loop buffer block reader
module tb_loop_buffer_block_reader;
  typedef struct {
    logic [63:0]  data;
    logic         sof;
    logic         eof;
    logic [255:0] info;
  } word_t;

  typedef struct {
    logic [255:0] info;
    logic [8:0]   len;
  } blk_t;

  logic        rd_clk = 1'b0;
  logic        rd_rst_n = 1'b0;
  logic [8:0]  cfg_blk_len = '0;
  logic        busy;
  logic [31:0] blk_cnt, stall_cnt;

  loop_buffer_block_reader_if #(.RDATA_WIDTH(64), .RADDR_WIDTH(8), .INFO_WIDTH(256)) bus ();

  loop_buffer_block_reader #(
    .RDATA_WIDTH(64), .RADDR_WIDTH(8), .READ_LATENCY(3), .INFO_WIDTH(256), .OFIFO_DEPTH(8)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst_n    (rd_rst_n),
    .cfg_blk_len (cfg_blk_len),
    .bus         (bus),
    .busy        (busy),
    .blk_cnt     (blk_cnt),
    .stall_cnt   (stall_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  word_t exp_q[$];
  blk_t  blk_q[$];
  int    n_asserts = 0;
  int    n_fail = 0;
  int    rdy_cnt = 0;
  int    blk_acc = 0;
  int    ready_mode = 0;
  int    hold_cnt = 0;
  logic  last_acc_eof = 1'b0;
  logic [255:0] head_info = '0;
  logic [7:0]   addr_pipe [3];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mk_info(input logic [31:0] s);
    return {8{s}};
  endfunction

  task automatic push_expected(input logic [255:0] info, input int len_cfg);
    int words;
    word_t w;
    words = (len_cfg == 0) ? 256 : len_cfg;
    for (int i = 0; i < words; i++) begin
      w.data = {info[31:0], 24'h0, 8'(i)};
      w.sof  = (i == 0);
      w.eof  = (i == words - 1);
      w.info = info;
      exp_q.push_back(w);
    end
  endtask

  task automatic push_block(input logic [255:0] info, input int len_cfg);
    blk_t b;
    b.info = info;
    b.len  = 9'(len_cfg);
    blk_q.push_back(b);
    push_expected(info, len_cfg);
  endtask

  task automatic wait_rdy(input int target, input int budget);
    int n = 0;
    while (rdy_cnt < target && n < budget) begin
      @(negedge rd_clk); #1;
      n++;
    end
    check_eq("rdy_count", rdy_cnt, target);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.m_valid && n < budget) begin
      @(negedge rd_clk); #1;
      n++;
    end
    check_eq("m_valid_seen", bus.m_valid, 1);
  endtask

  // RAM model: data appears three cycles after the address and encodes block tag and address.
  always @(posedge rd_clk) begin
    addr_pipe[0] <= bus.buf_addr;
    addr_pipe[1] <= addr_pipe[0];
    addr_pipe[2] <= addr_pipe[1];
  end
  assign bus.buf_data = {head_info[31:0], 24'h0, addr_pipe[2]};

  always @(posedge rd_clk) begin
    #1;
    if (hold_cnt > 0) begin
      bus.m_ready = 1'b0;
      hold_cnt--;
    end else if (ready_mode == 1) begin
      bus.m_ready = ~bus.m_ready;
    end
  end

  always @(negedge rd_clk) begin
    if (rd_rst_n) begin
      if (bus.m_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_word", 1, 0);
        end else begin
          check_eq("m_data", bus.m_data, exp_q[0].data);
          check_eq("m_sof", bus.m_sof, exp_q[0].sof);
          check_eq("m_eof", bus.m_eof, exp_q[0].eof);
          check_eq("m_info", bus.m_info, exp_q[0].info);
          if (bus.m_ready) begin
            blk_acc      = exp_q[0].sof ? 1 : blk_acc + 1;
            last_acc_eof = exp_q[0].eof;
            void'(exp_q.pop_front());
          end
        end
      end
      if (bus.buf_rdy) begin
        rdy_cnt++;
        check_eq("rdy_after_eof", last_acc_eof, 1);
        last_acc_eof = 1'b0;
        if (blk_q.size() > 0) void'(blk_q.pop_front());
      end
    end
    if (blk_q.size() > 0) begin
      bus.buf_info_vld = 1'b1;
      bus.buf_info     = blk_q[0].info;
      cfg_blk_len      = blk_q[0].len;
      head_info        = blk_q[0].info;
    end else begin
      bus.buf_info_vld = 1'b0;
      bus.buf_info     = '0;
      cfg_blk_len      = '0;
    end
  end

  initial begin
    int first;
    int n;
    bus.m_ready = 1'b1;
    repeat (3) @(negedge rd_clk);
    #1;
    check_eq("rst_m_valid", bus.m_valid, 0);
    check_eq("rst_buf_rdy", bus.buf_rdy, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_buf_addr", bus.buf_addr, 0);
    check_eq("rst_m_info", bus.m_info, 0);
    check_eq("rst_blk_cnt", blk_cnt, 0);
    check_eq("rst_stall_cnt", stall_cnt, 0);
    rd_rst_n = 1'b1;
    repeat (2) @(negedge rd_clk);
    #1;

    // 1: four-word block, first-word latency
    push_block(mk_info(32'h1111_0001), 4);
    @(negedge rd_clk); #1;
    first = 0;
    for (int j = 1; j <= 20 && first == 0; j++) begin
      @(negedge rd_clk); #1;
      if (j == 1) begin
        check_eq("t1_addr0", bus.buf_addr, 0);
        check_eq("t1_busy", busy, 1);
      end
      if (bus.m_valid) first = j;
    end
    check_eq("t1_latency", first, 5);
    wait_rdy(1, 100);
    repeat (4) @(negedge rd_clk);
    #1;
    check_eq("t1_single_rdy", rdy_cnt, 1);
    check_eq("t1_last_addr", bus.buf_addr, 3);
    check_eq("t1_idle", busy, 0);

    // 2: full 256-word block, no address wrap
    push_block(mk_info(32'h2222_0002), 0);
    wait_rdy(2, 1000);
    check_eq("t2_last_addr", bus.buf_addr, 8'hFF);

    // 3: toggling ready with a 20-cycle hold; addresses must stall on credit
    ready_mode = 1;
    push_block(mk_info(32'h3333_0003), 32);
    wait_valid(50);
    repeat (6) @(negedge rd_clk);
    #1;
    hold_cnt = 20;
    repeat (19) @(negedge rd_clk);
    #1;
    check_eq("t3_addr_stalled", bus.buf_addr, 8'(blk_acc + 8));
    check_eq("t3_ready_low", bus.m_ready, 0);
    wait_rdy(3, 500);
    ready_mode = 0;
    hold_cnt = 0;
    bus.m_ready = 1'b1;

    // 4: back-to-back blocks of 3 and 1 words
    push_block(mk_info(32'h4444_0004), 3);
    push_block(mk_info(32'h4545_0045), 1);
    wait_rdy(5, 200);
    check_eq("t4_queue_empty", exp_q.size(), 0);

    // 5: reset in the middle of an 8-word block
    blk_acc = 0;
    push_block(mk_info(32'h5555_0005), 8);
    n = 0;
    while (blk_acc < 2 && n < 100) begin
      @(negedge rd_clk); #1;
      n++;
    end
    check_eq("t5_two_words", blk_acc, 2);
    rd_rst_n = 1'b0;
    #1;
    check_eq("t5_m_valid", bus.m_valid, 0);
    check_eq("t5_m_data", bus.m_data, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_addr", bus.buf_addr, 0);
    check_eq("t5_m_info", bus.m_info, 0);
    exp_q.delete();
    push_expected(mk_info(32'h5555_0005), 8);
    repeat (3) begin
      @(negedge rd_clk); #1;
      check_eq("t5_no_rdy", bus.buf_rdy, 0);
    end
    rd_rst_n = 1'b1;
    wait_rdy(6, 200);
    check_eq("t5_last_addr", bus.buf_addr, 7);

    // 6: statistics over three blocks with seven stall cycles
    @(negedge rd_clk); #1;
    rd_rst_n = 1'b0;
    repeat (2) @(negedge rd_clk);
    #1;
    rd_rst_n = 1'b1;
    bus.m_ready = 1'b0;
    push_block(mk_info(32'h6666_0006), 2);
    push_block(mk_info(32'h6767_0067), 2);
    push_block(mk_info(32'h6868_0068), 2);
    wait_valid(50);
    repeat (7) @(posedge rd_clk);
    #1;
    bus.m_ready = 1'b1;
    wait_rdy(9, 200);
`ifdef LOOP_RD_STATS_EN
    check_eq("t6_blk_cnt", blk_cnt, 3);
    check_eq("t6_stall_cnt", stall_cnt, 7);
`else
    check_eq("t6_blk_cnt", blk_cnt, 0);
    check_eq("t6_stall_cnt", stall_cnt, 0);
`endif
    check_eq("end_queue_empty", exp_q.size(), 0);
    check_eq("end_blk_queue_empty", blk_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
